// File: rtl/mem_out_arbiter_pkg.sv
// Shared constants for the memory output arbiter slice:
// mode/source encodings, output FSM states, counter sizing.
package mem_out_arbiter_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;
  localparam logic SRC_SDRAM  = 1'b0;
  localparam logic SRC_FLASH  = 1'b1;

  localparam logic [0:0] OUT_EMPTY = 1'b0;
  localparam logic [0:0] OUT_FULL  = 1'b1;

  function automatic int cnt_w(int smax);
    return (smax > 0) ? $clog2(smax + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_out_arbiter_if.sv
// Handshake bundle between the two memory sources,
// the output sink and the arbiter.
interface mem_out_arbiter_if #(
  parameter int DATA_W = 8
) ();

  logic              src0_valid;
  logic [DATA_W-1:0] src0_data;
  logic              src0_ready;
  logic              src1_valid;
  logic [DATA_W-1:0] src1_data;
  logic              src1_ready;
  logic              prio_mode;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_src;
  logic              out_ready;

  modport master (
    output src0_valid, src0_data,
    output src1_valid, src1_data,
    output prio_mode, out_ready,
    input  src0_ready, src1_ready,
    input  out_valid, out_data, out_src
  );

  modport slave (
    input  src0_valid, src0_data,
    input  src1_valid, src1_data,
    input  prio_mode, out_ready,
    output src0_ready, src1_ready,
    output out_valid, out_data, out_src
  );

endinterface

// File: rtl/mem_arb_hold.sv
// One-entry valid/ready holding register; ready is
// purely registered so it never depends on in_valid.
module mem_arb_hold #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              drain,
  output logic              hold_valid,
  output logic [DATA_W-1:0] hold_data
);

  assign in_ready = !hold_valid;

  // capture needs empty, drain needs full: never both
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (in_valid && in_ready) begin
      hold_valid <= 1'b1;
      hold_data  <= in_data;
    end else if (drain) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_out_arbiter.sv
// Two-source output arbiter: round-robin or src0
// priority with a starvation limit, registered output.
module mem_out_arbiter
  import mem_out_arbiter_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 3
) (
  input logic         clock,
  input logic         reset_n,
  mem_out_arbiter_if.slave bus
);

  localparam int CW = cnt_w(STARVE_MAX);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  logic              h0_valid, h1_valid;
  logic [DATA_W-1:0] h0_data, h1_data;
  logic              drain0, drain1;
  logic [0:0]        state;
  logic [DATA_W-1:0] out_data_q;
  logic              out_src_q;
  logic              last_grant;
  logic [CW-1:0]     starve_cnt;
  logic              load, tie, starved, winner;

  mem_arb_hold #(.DATA_W(DATA_W)) u_hold0 (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (bus.src0_valid),
    .in_data    (bus.src0_data),
    .in_ready   (bus.src0_ready),
    .drain      (drain0),
    .hold_valid (h0_valid),
    .hold_data  (h0_data)
  );

  mem_arb_hold #(.DATA_W(DATA_W)) u_hold1 (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (bus.src1_valid),
    .in_data    (bus.src1_data),
    .in_ready   (bus.src1_ready),
    .drain      (drain1),
    .hold_valid (h1_valid),
    .hold_data  (h1_data)
  );

  always_comb begin
    tie     = h0_valid && h1_valid;
    starved = (STARVE_MAX != 0) && (starve_cnt == SMAX);
    load    = ((state == OUT_EMPTY) || bus.out_ready)
              && (h0_valid || h1_valid);
    winner  = SRC_SDRAM;
    unique case (1'b1)
      !tie:
        winner = !h0_valid;
      tie && (bus.prio_mode == MODE_RR):
        winner = !last_grant;
      tie && (bus.prio_mode == MODE_FIXED):
        winner = starved ? SRC_FLASH : SRC_SDRAM;
    endcase
    drain0 = load && (winner == SRC_SDRAM);
    drain1 = load && (winner == SRC_FLASH);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= OUT_EMPTY;
      out_data_q <= '0;
      out_src_q  <= SRC_SDRAM;
      last_grant <= SRC_FLASH;
      starve_cnt <= '0;
    end else begin
      unique case (state)
        OUT_EMPTY: if (load) state <= OUT_FULL;
        OUT_FULL:  if (bus.out_ready && !load)
                     state <= OUT_EMPTY;
        default:   state <= OUT_EMPTY;
      endcase
      if (load) begin
        out_data_q <= winner ? h1_data : h0_data;
        out_src_q  <= winner;
        last_grant <= winner;
        // counts src0 wins that bypass a waiting src1
        if (winner == SRC_FLASH)
          starve_cnt <= '0;
        else if (h1_valid && (starve_cnt != SMAX))
          starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  assign bus.out_valid = (state == OUT_FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_mem_out_arbiter.sv
// Directed scoreboard bench for mem_out_arbiter
// (STARVE_MAX=3 main instance, STARVE_MAX=0 strict instance).
module tb_mem_out_arbiter;
  import mem_out_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic       s0v, s1v, pm, ordy;
  logic [7:0] s0d, s1d;
  logic       sel;

  mem_out_arbiter_if #(.DATA_W(8)) b0 ();
  mem_out_arbiter_if #(.DATA_W(8)) b1 ();

  assign b0.src0_valid = s0v;
  assign b0.src0_data  = s0d;
  assign b0.src1_valid = s1v;
  assign b0.src1_data  = s1d;
  assign b0.prio_mode  = pm;
  assign b0.out_ready  = ordy;
  assign b1.src0_valid = s0v;
  assign b1.src0_data  = s0d;
  assign b1.src1_valid = s1v;
  assign b1.src1_data  = s1d;
  assign b1.prio_mode  = pm;
  assign b1.out_ready  = ordy;

  mem_out_arbiter #(.DATA_W(8), .STARVE_MAX(3)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (b0.slave)
  );

  mem_out_arbiter #(.DATA_W(8), .STARVE_MAX(0)) u_dut_strict (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (b1.slave)
  );

  logic       r0, r1, ov, os;
  logic [7:0] od;
  assign r0 = sel ? b1.src0_ready : b0.src0_ready;
  assign r1 = sel ? b1.src1_ready : b0.src1_ready;
  assign ov = sel ? b1.out_valid  : b0.out_valid;
  assign os = sel ? b1.out_src    : b0.out_src;
  assign od = sel ? b1.out_data   : b0.out_data;

  int checks = 0;
  int failures = 0;
  int cyc_n = 1;
  int rmode = 0;
  int pm_switch_at = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [8:0] expq[$];
  int out_cyc[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    s0v = (q0.size() != 0);
    s0d = s0v ? q0[0] : 8'h00;
    s1v = (q1.size() != 0);
    s1d = s1v ? q1[0] : 8'h00;
  endtask

  task automatic cyc();
    logic h0, h1, ho;
    logic [8:0] e;
    h0 = s0v && r0;
    h1 = s1v && r1;
    ho = ov && ordy;
    if (ho) begin
      if (expq.size() == 0) begin
        chk("extra_out", {23'd0, os, od}, 32'hffff_ffff);
      end else begin
        e = expq.pop_front();
        chk("out_word", {23'd0, os, od}, {23'd0, e});
        out_cyc.push_back(cyc_n);
      end
    end
    @(posedge clock);
    #1;
    cyc_n++;
    if (h0) void'(q0.pop_front());
    if (h1) void'(q1.pop_front());
    drive_src();
  endtask

  task automatic run(int budget);
    for (int i = 0; i < budget && expq.size() != 0; i++) begin
      if (pm_switch_at != 0 && cyc_n >= pm_switch_at)
        pm = MODE_RR;
      ordy = (rmode == 0) ? 1'b1 : (cyc_n % 2 == 0);
      cyc();
    end
    chk("drain_timeout", expq.size(), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    s0v = 1'b0;
    s1v = 1'b0;
    s0d = 8'h00;
    s1d = 8'h00;
    ordy = 1'b0;
    q0.delete();
    q1.delete();
    expq.delete();
    out_cyc.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    cyc_n = 1;
  endtask

  initial begin
    sel = 1'b0;
    s0v = 1'b0; s1v = 1'b0;
    s0d = 8'h00; s1d = 8'h00;
    pm = MODE_RR;
    ordy = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", ov, 0);
    chk("rst_out_data", od, 0);
    chk("rst_out_src", os, 0);
    chk("rst_src0_ready", r0, 1);
    chk("rst_src1_ready", r1, 1);
    reset_n = 1'b1;

    // single source, one word every two cycles
    do_reset();
    q0 = '{8'h11, 8'h22, 8'h33};
    expq = '{9'h011, 9'h022, 9'h033};
    rmode = 0;
    drive_src();
    run(40);
    chk("t2_count", out_cyc.size(), 3);
    if (out_cyc.size() == 3) begin
      chk("t2_latency", out_cyc[0], 3);
      chk("t2_gap1", out_cyc[1] - out_cyc[0], 2);
      chk("t2_gap2", out_cyc[2] - out_cyc[1], 2);
    end

    // round-robin contention, one word per cycle
    do_reset();
    q0 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    q1 = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    expq = '{9'h0A0, 9'h1B0, 9'h0A1, 9'h1B1,
             9'h0A2, 9'h1B2, 9'h0A3, 9'h1B3};
    rmode = 0;
    drive_src();
    run(40);
    chk("t3_count", out_cyc.size(), 8);
    if (out_cyc.size() == 8)
      chk("t3_rate", out_cyc[7] - out_cyc[0], 7);

    // fixed priority with starvation limit 3
    do_reset();
    pm = MODE_FIXED;
    q0 = '{8'h40, 8'h41, 8'h42, 8'h43,
           8'h44, 8'h45, 8'h46, 8'h47};
    q1 = '{8'h80, 8'h81};
    expq = '{9'h040, 9'h041, 9'h042, 9'h180, 9'h043,
             9'h044, 9'h045, 9'h181, 9'h046, 9'h047};
    rmode = 1;
    drive_src();
    run(80);

    // strict priority build
    sel = 1'b1;
    do_reset();
    pm = MODE_FIXED;
    q0 = '{8'h40, 8'h41, 8'h42, 8'h43,
           8'h44, 8'h45, 8'h46, 8'h47};
    q1 = '{8'h80, 8'h81};
    expq = '{9'h040, 9'h041, 9'h042, 9'h043, 9'h044,
             9'h045, 9'h046, 9'h047, 9'h180, 9'h181};
    rmode = 1;
    drive_src();
    run(80);
    sel = 1'b0;

    // backpressure holds output, both holds fill
    do_reset();
    pm = MODE_RR;
    q0 = '{8'h5A, 8'h5B};
    q1 = '{8'hC0};
    drive_src();
    ordy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (cyc_n >= 3) begin
        chk("t5_hold_valid", ov, 1);
        chk("t5_hold_data", od, 8'h5A);
      end
    end
    chk("t5_src0_ready", r0, 0);
    chk("t5_src1_ready", r1, 0);
    expq = '{9'h05A, 9'h1C0, 9'h05B};
    rmode = 0;
    run(40);

    // mode switch after two src0 wins
    do_reset();
    pm = MODE_FIXED;
    q0 = '{8'h60, 8'h61, 8'h62, 8'h63};
    q1 = '{8'h70, 8'h71};
    expq = '{9'h060, 9'h061, 9'h170,
             9'h062, 9'h171, 9'h063};
    rmode = 1;
    pm_switch_at = 5;
    drive_src();
    run(60);
    pm_switch_at = 0;

    // asynchronous reset mid-stream
    do_reset();
    pm = MODE_RR;
    q0 = '{8'h91, 8'h92, 8'h93};
    q1 = '{8'hD1, 8'hD2};
    drive_src();
    ordy = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("t1_pre_valid", ov, 1);
    chk("t1_pre_src0_ready", r0, 0);
    chk("t1_pre_src1_ready", r1, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t1_out_valid", ov, 0);
    chk("t1_out_data", od, 0);
    chk("t1_out_src", os, 0);
    chk("t1_src0_ready", r0, 1);
    chk("t1_src1_ready", r1, 1);
    s0v = 1'b0;
    s1v = 1'b0;
    q0.delete();
    q1.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
